uart_core_cfg: RTL and testbench

//  Parametrised full-duplex UART with runtime baud divisor, parity mode and stop-bit count.
//  RX and TX each have a power-of-two first-word-fall-through FIFO and sticky error flags.

---
 rtl/uart_core_cfg.sv | 378 +++++++++++++++++++++++++++++++++++++
 tb/tb_uart_core_cfg.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_core_cfg.sv
// -----------------------------------------------------------------------------
// uart_core_cfg
//   Full-duplex 8-bit UART (LSB first) with a runtime clocks-per-bit divisor,
//   runtime parity mode (none / even / odd) and one or two TX stop bits.
//   RX and TX each own a power-of-two first-word-fall-through FIFO; error
//   conditions are reported through sticky flags cleared by err_clr.
//
//   Ports
//     clk, rst_n            system clock, asynchronous active-low reset
//     cfg_div               clocks per bit (values below 4 behave as 4)
//     cfg_parity            00 none, 01 even, 10 odd, 11 none
//     cfg_stop2             two stop bits on TX
//     err_clr               clears every sticky error flag
//     rx / tx               serial pins (rx is asynchronous to clk)
//     rx_rden, rx_rdata     RX FIFO pop and head byte
//     rx_count              RX FIFO occupancy
//     rx_frame_err, rx_par_err, rx_overrun, rx_underrun   sticky RX flags
//     tx_wdata, tx_wten     TX FIFO push
//     tx_count, tx_overrun  TX FIFO occupancy and sticky drop flag
//     tx_busy               TX frame in progress or TX FIFO not empty
// -----------------------------------------------------------------------------

// Byte-wide FWFT FIFO used for both directions. The head entry is shown
// combinationally from storage; an empty FIFO presents zero.
module uart_fifo #(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    wdata,
  input  logic          pop,
  output logic [7:0]    rdata,
  output logic [AW:0]   count
);
  localparam int DEPTH = 2 ** AW;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // A push into a full FIFO is still accepted when a pop frees the slot.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign rdata   = empty ? 8'h00 : mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; contents are only observable
  // through the occupancy count, so resetting it would buy nothing.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end
endmodule

module uart_core_cfg #(
  parameter int DIV_W   = 16,
  parameter int FIFO_AW = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DIV_W-1:0]   cfg_div,
  input  logic [1:0]         cfg_parity,
  input  logic               cfg_stop2,
  input  logic               err_clr,
  input  logic               rx,
  output logic               tx,
  input  logic               rx_rden,
  output logic [7:0]         rx_rdata,
  output logic [FIFO_AW:0]   rx_count,
  output logic               rx_frame_err,
  output logic               rx_par_err,
  output logic               rx_overrun,
  output logic               rx_underrun,
  input  logic [7:0]         tx_wdata,
  input  logic               tx_wten,
  output logic [FIFO_AW:0]   tx_count,
  output logic               tx_overrun,
  output logic               tx_busy
);
  localparam int DEPTH = 2 ** FIFO_AW;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  // Configuration as seen at a frame start.
  logic [DIV_W-1:0] div_eff;
  logic             par_en_cfg;
  logic             par_odd_cfg;

  assign div_eff     = (cfg_div < DIV_W'(4)) ? DIV_W'(4) : cfg_div;
  assign par_en_cfg  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
  assign par_odd_cfg = (cfg_parity == 2'b10);

  // ---------------------------------------------------------------------------
  // RX front end: 2-FF synchroniser followed by a 3-tap majority filter.
  // ---------------------------------------------------------------------------
  logic       rx_s1;
  logic       rx_s2;
  logic [2:0] rx_taps;
  logic       rx_bit;
  logic       rx_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_taps <= 3'b111;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_taps <= {rx_taps[1:0], rx_s2};
    end
  end

  assign rx_bit  = (rx_taps[0] & rx_taps[1]) | (rx_taps[0] & rx_taps[2]) |
                   (rx_taps[1] & rx_taps[2]);
  // rx_taps[0] holds the previous synchronised sample.
  assign rx_fall = rx_taps[0] & ~rx_s2;

  // ---------------------------------------------------------------------------
  // RX FSM
  // ---------------------------------------------------------------------------
  state_e           rx_state;
  state_e           rx_state_d;
  logic [DIV_W-1:0] rx_cnt;
  logic [DIV_W-1:0] rx_div_l;
  logic             rx_par_en_l;
  logic             rx_par_odd_l;
  logic [2:0]       rx_idx;
  logic [7:0]       rx_shreg;
  logic             rx_par_bad;
  logic             rx_exp;
  logic             rx_push;
  logic             rx_ferr_set;
  logic             rx_full;

  assign rx_exp = (rx_cnt == DIV_W'(1));

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    rx_state_d  = rx_state;
    rx_push     = 1'b0;
    rx_ferr_set = 1'b0;
    case (rx_state)
      ST_IDLE:   if (rx_fall) rx_state_d = ST_START;
      ST_START:  if (rx_exp) rx_state_d = rx_bit ? ST_IDLE : ST_DATA;
      ST_DATA:   if (rx_exp && rx_idx == 3'd7)
                   rx_state_d = rx_par_en_l ? ST_PARITY : ST_STOP;
      ST_PARITY: if (rx_exp) rx_state_d = ST_STOP;
      ST_STOP: begin
        if (rx_exp) begin
          rx_state_d = ST_IDLE;
          if (rx_bit) rx_push     = 1'b1;
          else        rx_ferr_set = 1'b1;
        end
      end
      default:   rx_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= ST_IDLE;
    else        rx_state <= rx_state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt       <= '0;
      rx_div_l     <= '0;
      rx_par_en_l  <= 1'b0;
      rx_par_odd_l <= 1'b0;
      rx_idx       <= '0;
      rx_shreg     <= '0;
      rx_par_bad   <= 1'b0;
    end else if (rx_state == ST_IDLE) begin
      if (rx_fall) begin
        // First expiry lands in the middle of the start bit.
        rx_div_l     <= div_eff;
        rx_par_en_l  <= par_en_cfg;
        rx_par_odd_l <= par_odd_cfg;
        rx_cnt       <= div_eff >> 1;
      end
    end else if (rx_exp) begin
      rx_cnt <= rx_div_l;
      case (rx_state)
        ST_START: begin
          rx_idx     <= '0;
          rx_par_bad <= 1'b0;
        end
        ST_DATA: begin
          rx_shreg <= {rx_bit, rx_shreg[7:1]};
          rx_idx   <= rx_idx + 3'd1;
        end
        // Even: mismatch when XOR(data, pbit) = 1; odd inverts that.
        ST_PARITY: rx_par_bad <= (^rx_shreg) ^ rx_bit ^ rx_par_odd_l;
        default: ;
      endcase
    end else begin
      rx_cnt <= rx_cnt - DIV_W'(1);
    end
  end

  uart_fifo #(.AW(FIFO_AW)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .wdata (rx_shreg),
    .pop   (rx_rden),
    .rdata (rx_rdata),
    .count (rx_count)
  );

  assign rx_full = (rx_count == (FIFO_AW+1)'(DEPTH));

  // ---------------------------------------------------------------------------
  // TX FSM; tx is registered one cycle behind the state that selects it.
  // ---------------------------------------------------------------------------
  state_e           tx_state;
  state_e           tx_state_d;
  logic [DIV_W-1:0] tx_cnt;
  logic [DIV_W-1:0] tx_div_l;
  logic             tx_par_en_l;
  logic             tx_stop2_l;
  logic             tx_stop_idx;
  logic             tx_par_bit;
  logic [2:0]       tx_idx;
  logic [7:0]       tx_shreg;
  logic             tx_exp;
  logic             tx_pop;
  logic             tx_bit;
  logic [7:0]       tx_fifo_rdata;
  logic             tx_full;

  assign tx_exp = (tx_cnt == DIV_W'(1));

  always_comb begin
    tx_state_d = tx_state;
    tx_pop     = 1'b0;
    tx_bit     = 1'b1;
    case (tx_state)
      ST_IDLE: begin
        if (tx_count != '0) begin
          tx_pop     = 1'b1;
          tx_state_d = ST_START;
        end
      end
      ST_START: begin
        tx_bit = 1'b0;
        if (tx_exp) tx_state_d = ST_DATA;
      end
      ST_DATA: begin
        tx_bit = tx_shreg[0];
        if (tx_exp && tx_idx == 3'd7)
          tx_state_d = tx_par_en_l ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        tx_bit = tx_par_bit;
        if (tx_exp) tx_state_d = ST_STOP;
      end
      ST_STOP: begin
        tx_bit = 1'b1;
        // Back-to-back frames start right after the last stop bit.
        if (tx_exp && !(tx_stop2_l && !tx_stop_idx)) begin
          if (tx_count != '0) begin
            tx_pop     = 1'b1;
            tx_state_d = ST_START;
          end else begin
            tx_state_d = ST_IDLE;
          end
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= ST_IDLE;
    else        tx_state <= tx_state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt      <= '0;
      tx_div_l    <= '0;
      tx_par_en_l <= 1'b0;
      tx_stop2_l  <= 1'b0;
      tx_stop_idx <= 1'b0;
      tx_par_bit  <= 1'b0;
      tx_idx      <= '0;
      tx_shreg    <= '0;
      tx          <= 1'b1;
    end else begin
      tx <= tx_bit;
      if (tx_pop) begin
        tx_div_l    <= div_eff;
        tx_par_en_l <= par_en_cfg;
        tx_stop2_l  <= cfg_stop2;
        tx_par_bit  <= (^tx_fifo_rdata) ^ par_odd_cfg;
        tx_shreg    <= tx_fifo_rdata;
        tx_cnt      <= div_eff;
        tx_idx      <= '0;
        tx_stop_idx <= 1'b0;
      end else if (tx_state != ST_IDLE) begin
        if (tx_exp) begin
          tx_cnt <= tx_div_l;
          if (tx_state == ST_DATA) begin
            tx_shreg <= {1'b0, tx_shreg[7:1]};
            tx_idx   <= tx_idx + 3'd1;
          end
          if (tx_state == ST_STOP) tx_stop_idx <= 1'b1;
        end else begin
          tx_cnt <= tx_cnt - DIV_W'(1);
        end
      end
    end
  end

  uart_fifo #(.AW(FIFO_AW)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_wten),
    .wdata (tx_wdata),
    .pop   (tx_pop),
    .rdata (tx_fifo_rdata),
    .count (tx_count)
  );

  assign tx_full = (tx_count == (FIFO_AW+1)'(DEPTH));
  assign tx_busy = (tx_state != ST_IDLE) || (tx_count != '0);

  // ---------------------------------------------------------------------------
  // Sticky flags: a set in the same cycle as err_clr wins.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_frame_err <= 1'b0;
      rx_par_err   <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_underrun  <= 1'b0;
      tx_overrun   <= 1'b0;
    end else begin
      rx_frame_err <= rx_ferr_set | (rx_frame_err & ~err_clr);
      rx_par_err   <= (rx_push & rx_par_bad) | (rx_par_err & ~err_clr);
      rx_overrun   <= (rx_push & rx_full & ~rx_rden) | (rx_overrun & ~err_clr);
      rx_underrun  <= (rx_rden & (rx_count == '0)) | (rx_underrun & ~err_clr);
      tx_overrun   <= (tx_wten & tx_full & ~tx_pop) | (tx_overrun & ~err_clr);
    end
  end
endmodule

// File: tb/tb_uart_core_cfg.sv
// -----------------------------------------------------------------------------
// tb_uart_core_cfg
//   Directed bench for uart_core_cfg: loopback frames, parity bit values,
//   start-glitch rejection, hand-built RX frames with framing and parity
//   errors, FIFO fill/overrun/underrun, reset mid-frame, two stop bits and
//   divisor clamping with a mid-frame config change.
// -----------------------------------------------------------------------------
module tb_uart_core_cfg;
  localparam int DIV_W   = 16;
  localparam int FIFO_AW = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [DIV_W-1:0]   cfg_div;
  logic [1:0]         cfg_parity;
  logic               cfg_stop2;
  logic               err_clr;
  logic               rx;
  logic               tx;
  logic               rx_rden;
  logic [7:0]         rx_rdata;
  logic [FIFO_AW:0]   rx_count;
  logic               rx_frame_err;
  logic               rx_par_err;
  logic               rx_overrun;
  logic               rx_underrun;
  logic [7:0]         tx_wdata;
  logic               tx_wten;
  logic [FIFO_AW:0]   tx_count;
  logic               tx_overrun;
  logic               tx_busy;

  logic loop_en;
  logic rx_drv;

  assign rx = loop_en ? tx : rx_drv;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_core_cfg #(.DIV_W(DIV_W), .FIFO_AW(FIFO_AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_div      (cfg_div),
    .cfg_parity   (cfg_parity),
    .cfg_stop2    (cfg_stop2),
    .err_clr      (err_clr),
    .rx           (rx),
    .tx           (tx),
    .rx_rden      (rx_rden),
    .rx_rdata     (rx_rdata),
    .rx_count     (rx_count),
    .rx_frame_err (rx_frame_err),
    .rx_par_err   (rx_par_err),
    .rx_overrun   (rx_overrun),
    .rx_underrun  (rx_underrun),
    .tx_wdata     (tx_wdata),
    .tx_wten      (tx_wten),
    .tx_count     (tx_count),
    .tx_overrun   (tx_overrun),
    .tx_busy      (tx_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // All stimulus and sampling happens 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) tick();
  endtask

  task automatic push_tx(input logic [7:0] d);
    tx_wdata = d;
    tx_wten  = 1'b1;
    tick();
    tx_wten  = 1'b0;
  endtask

  task automatic pop_rx();
    rx_rden = 1'b1;
    tick();
    rx_rden = 1'b0;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic wait_tx_low(input string tag, input int budget);
    int n;
    n = 0;
    while (tx !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    if (tx !== 1'b0) check(tag, 32'(tx), 32'd0);
  endtask

  task automatic wait_rx_count(input string tag, input int budget, output int n);
    n = 0;
    while (rx_count == '0 && n < budget) begin
      tick();
      n++;
    end
    if (rx_count == '0) check(tag, 32'(rx_count), 32'd1);
  endtask

  task automatic wait_tx_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (tx_busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    if (tx_busy !== 1'b0) check(tag, 32'(tx_busy), 32'd0);
  endtask

  // Samples nbits mid-bit from the start-bit falling edge, bits[0] = start.
  task automatic capture_frame(input int div, input int nbits, output logic [15:0] bits);
    bits = '0;
    wait_tx_low("cap_start_timeout", 100);
    tick_n(div / 2);
    for (int i = 0; i < nbits; i++) begin
      bits[i] = tx;
      tick_n(div);
    end
  endtask

  // Length of the current run of tx at level lvl, bounded.
  task automatic run_length(input logic lvl, output int n);
    n = 0;
    while (tx === lvl && n < 1000) begin
      tick();
      n++;
    end
  endtask

  task automatic send_rx_frame(input logic [7:0] d, input bit par_en, input bit pbit,
                               input bit stopb, input int div);
    rx_drv = 1'b0;
    tick_n(div);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      tick_n(div);
    end
    if (par_en) begin
      rx_drv = pbit;
      tick_n(div);
    end
    rx_drv = stopb;
    tick_n(div);
    rx_drv = 1'b1;
    tick_n(div);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    int          w;
    int          low_run;
    int          high_run;
    logic [15:0] frame;

    rst_n      = 1'b0;
    cfg_div    = 16'd16;
    cfg_parity = 2'b00;
    cfg_stop2  = 1'b0;
    err_clr    = 1'b0;
    rx_rden    = 1'b0;
    tx_wdata   = 8'h00;
    tx_wten    = 1'b0;
    loop_en    = 1'b1;
    rx_drv     = 1'b1;

    // Reset state.
    tick_n(3);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_counts", {24'd0, rx_count, tx_count}, 32'd0);
    check("rst_rdata", 32'(rx_rdata), 32'h00);
    check("rst_flags_busy", {27'd0, rx_frame_err, rx_par_err, rx_overrun, rx_underrun,
                             tx_overrun}, 32'd0);
    check("rst_busy", 32'(tx_busy), 32'd0);
    rst_n = 1'b1;
    tick_n(3);

    // 1. Loopback at div=16, no parity.
    tx_wdata = 8'hA5;
    tx_wten  = 1'b1;
    tick();
    tx_wten  = 1'b0;
    check("t1_tx_edge1", 32'(tx), 32'd1);
    tick();
    check("t1_tx_edge2_high", 32'(tx), 32'd1);
    tick();
    check("t1_tx_fall", 32'(tx), 32'd0);
    cyc = 2;
    wait_rx_count("t1_rx_timeout", 300, w);
    cyc += w;
    check("t1_latency_ok", 32'(cyc <= 168), 32'd1);
    check("t1_rx_count", 32'(rx_count), 32'd1);
    check("t1_rx_rdata", 32'(rx_rdata), 32'hA5);
    check("t1_flags", {28'd0, rx_frame_err, rx_par_err, rx_overrun, rx_underrun}, 32'd0);
    pop_rx();
    check("t1_rx_empty", 32'(rx_count), 32'd0);
    wait_tx_idle("t1_idle_timeout", 400);

    // 2. Parity bit values at div=8.
    cfg_div    = 16'd8;
    cfg_parity = 2'b01;
    push_tx(8'h07);
    capture_frame(8, 11, frame);
    check("t2_even_frame", 32'(frame), 32'h060E);
    wait_rx_count("t2_even_rx_timeout", 200, w);
    check("t2_even_rdata", 32'(rx_rdata), 32'h07);
    check("t2_even_par_err", 32'(rx_par_err), 32'd0);
    pop_rx();
    wait_tx_idle("t2_idle_timeout", 200);
    tick_n(8);
    cfg_parity = 2'b10;
    push_tx(8'h07);
    capture_frame(8, 11, frame);
    check("t2_odd_frame", 32'(frame), 32'h040E);
    wait_rx_count("t2_odd_rx_timeout", 200, w);
    check("t2_odd_rdata", 32'(rx_rdata), 32'h07);
    check("t2_odd_par_err", 32'(rx_par_err), 32'd0);
    pop_rx();
    wait_tx_idle("t2_odd_idle_timeout", 200);
    tick_n(8);

    // 3. Start glitch at div=16.
    loop_en    = 1'b0;
    rx_drv     = 1'b1;
    cfg_div    = 16'd16;
    cfg_parity = 2'b00;
    tick_n(4);
    rx_drv = 1'b0;
    tick_n(4);
    rx_drv = 1'b1;
    tick_n(40);
    check("t3_rx_count", 32'(rx_count), 32'd0);
    check("t3_flags", {28'd0, rx_frame_err, rx_par_err, rx_overrun, rx_underrun}, 32'd0);

    // 4. Hand-built frames: bad stop, then good, then parity mismatch.
    send_rx_frame(8'h3C, 1'b0, 1'b0, 1'b0, 16);
    check("t4_frame_err", 32'(rx_frame_err), 32'd1);
    check("t4_rx_count", 32'(rx_count), 32'd0);
    pulse_err_clr();
    check("t4_frame_err_clr", 32'(rx_frame_err), 32'd0);
    send_rx_frame(8'h3C, 1'b0, 1'b0, 1'b1, 16);
    check("t4_good_count", 32'(rx_count), 32'd1);
    check("t4_good_rdata", 32'(rx_rdata), 32'h3C);
    pop_rx();
    cfg_parity = 2'b01;
    send_rx_frame(8'h3C, 1'b1, 1'b1, 1'b1, 16);
    check("t4_par_count", 32'(rx_count), 32'd1);
    check("t4_par_rdata", 32'(rx_rdata), 32'h3C);
    check("t4_par_err", 32'(rx_par_err), 32'd1);
    pulse_err_clr();
    pop_rx();
    check("t4_par_err_clr", 32'(rx_par_err), 32'd0);
    cfg_parity = 2'b00;

    // 5. Fill RX FIFO past depth through loopback.
    loop_en = 1'b1;
    cfg_div = 16'd8;
    for (int i = 0; i < 9; i++) push_tx(8'(i));
    check("t5_tx_overrun", 32'(tx_overrun), 32'd0);
    wait_tx_idle("t5_idle_timeout", 2000);
    tick_n(24);
    check("t5_rx_count_full", 32'(rx_count), 32'd8);
    check("t5_rx_overrun", 32'(rx_overrun), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t5_pop%0d", i), 32'(rx_rdata), 32'(i));
      pop_rx();
    end
    check("t5_underrun_before", 32'(rx_underrun), 32'd0);
    pop_rx();
    check("t5_underrun", 32'(rx_underrun), 32'd1);
    check("t5_rx_empty", 32'(rx_count), 32'd0);

    // 6. TX FIFO overrun, then reset mid-frame.
    loop_en = 1'b0;
    rx_drv  = 1'b1;
    for (int i = 0; i < 10; i++) push_tx(8'h00);
    check("t6_tx_count_full", 32'(tx_count), 32'd8);
    check("t6_tx_overrun", 32'(tx_overrun), 32'd1);
    check("t6_tx_midframe", 32'(tx), 32'd0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_tx", 32'(tx), 32'd1);
    check("t6_rst_counts", {24'd0, rx_count, tx_count}, 32'd0);
    check("t6_rst_flags", {27'd0, rx_frame_err, rx_par_err, rx_overrun, rx_underrun,
                           tx_overrun}, 32'd0);
    check("t6_rst_busy", 32'(tx_busy), 32'd0);
    tick_n(2);
    rst_n = 1'b1;
    tick_n(2);

    // Two stop bits at div=10, two back-to-back frames of 0x00.
    cfg_div   = 16'd10;
    cfg_stop2 = 1'b1;
    push_tx(8'h00);
    push_tx(8'h00);
    wait_tx_low("t6_start_timeout", 50);
    run_length(1'b0, low_run);
    run_length(1'b1, high_run);
    check("t6_low_run", 32'(low_run), 32'd90);
    check("t6_stop2_high", 32'(high_run), 32'd20);
    check("t6_second_start", 32'(tx), 32'd0);
    wait_tx_idle("t6_idle_timeout", 400);
    tick_n(4);

    // Divisor clamp, with a divisor change mid-frame that must not apply.
    cfg_stop2 = 1'b0;
    cfg_div   = 16'd2;
    push_tx(8'h00);
    wait_tx_low("t7_start_timeout", 50);
    cfg_div = 16'd10;
    run_length(1'b0, low_run);
    check("t7_clamp_low_run", 32'(low_run), 32'd36);
    wait_tx_idle("t7_idle_timeout", 200);
    check("t7_no_overrun", 32'(tx_overrun), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
